// File: rtl/game_status_bar_if.sv
// game_status_bar_if: HUD status-bar control and pixel-stream bundle.
`default_nettype none

interface game_status_bar_if #(
    parameter int VAL_W = 5
);
    logic             enable;
    logic             frame_tick;
    logic [VAL_W-1:0] value;
    logic [10:0]      VGA_xpos;
    logic [10:0]      VGA_ypos;
    logic [11:0]      VGA_data;
    logic             anim_busy;

    modport master (
        output enable, frame_tick, value, VGA_xpos, VGA_ypos,
        input  VGA_data, anim_busy
    );

    modport slave (
        input  enable, frame_tick, value, VGA_xpos, VGA_ypos,
        output VGA_data, anim_busy
    );
endinterface

`default_nettype wire

// File: rtl/game_status_bar.sv
// game_status_bar: slewing segmented HUD bar with drain ghost, 2-stage pixel pipeline.
// Optional low-level blink enabled by defining STATUS_BAR_BLINK_EN.
`default_nettype none

module game_status_bar #(
    parameter int          X0           = 320,
    parameter int          Y0           = 52,
    parameter int          SEG_H        = 16,
    parameter int          SEG_W_LOG2   = 4,
    parameter int          SEG_MAX      = 9,
    parameter int          VAL_W        = 5,
    parameter int          LOW_THRESH   = 2,
    parameter int          BLINK_FRAMES = 16,
    parameter logic [11:0] FILL_COLOR   = 12'hF00,
    parameter logic [11:0] BORDER_COLOR = 12'hF00
) (
    input  wire logic         clk,
    input  wire logic         rst,
    game_status_bar_if.slave  bus
);
    localparam logic [10:0] X_LEFT  = 11'(X0);
    localparam logic [10:0] X_RIGHT = 11'(X0 + (SEG_MAX << SEG_W_LOG2));
    localparam logic [10:0] Y_TOP   = 11'(Y0);
    localparam logic [10:0] Y_BOT   = 11'(Y0 + SEG_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [4:0]   tgt_lvl, tgt_nxt;
    logic [4:0]   disp_lvl, disp_nxt;
    logic [4:0]   new_tgt;
    logic         busy;
    logic         blank;
    logic [VAL_W-1:0] val;

    assign val     = bus.value;
    assign new_tgt = (32'(val) > SEG_MAX) ? 5'(SEG_MAX) : 5'(val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tgt_lvl  <= 5'd0;
            disp_lvl <= 5'd0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tgt_lvl  <= tgt_nxt;
            disp_lvl <= disp_nxt;
            busy     <= (state != IDLE);
        end
    end

    // Every state steps toward the freshly latched target; the state only records direction.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_lvl;
        disp_nxt  = disp_lvl;
        if (!bus.enable) begin
            state_nxt = IDLE;
            tgt_nxt   = 5'd0;
            disp_nxt  = 5'd0;
        end else if (bus.frame_tick) begin
            tgt_nxt = new_tgt;
            if (new_tgt > disp_lvl) begin
                disp_nxt  = disp_lvl + 5'd1;
                state_nxt = (disp_lvl + 5'd1 == new_tgt) ? IDLE : FILL;
            end else if (new_tgt < disp_lvl) begin
                disp_nxt  = disp_lvl - 5'd1;
                state_nxt = (disp_lvl - 5'd1 == new_tgt) ? IDLE : DRAIN;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    assign bus.anim_busy = busy;

`ifdef STATUS_BAR_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          low;

    assign low = (disp_nxt != 5'd0) && (32'(disp_nxt) <= LOW_THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!bus.enable) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_tick) begin
            if (!low) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
        end
    end

    assign blank = blink_phase;
`else
    // Blink parameters only matter in the blink build; this folds to constant 0.
    assign blank = (LOW_THRESH < 0) && (BLINK_FRAMES < 0);
`endif

    // Stage 1: geometry classification of the incoming coordinate.
    logic [10:0] off;
    logic [4:0]  seg;
    logic        in_x, in_y, border_c, sep_c;
    logic        s1_inside, s1_border, s1_sep, s1_en;
    logic [4:0]  s1_seg;

    assign off      = bus.VGA_xpos - X_LEFT;
    assign seg      = 5'(off >> SEG_W_LOG2);
    assign in_x     = (bus.VGA_xpos >= X_LEFT) && (bus.VGA_xpos <= X_RIGHT);
    assign in_y     = (bus.VGA_ypos >= Y_TOP)  && (bus.VGA_ypos <= Y_BOT);
    assign border_c = (in_y && ((bus.VGA_xpos == X_LEFT) || (bus.VGA_xpos == X_RIGHT))) ||
                      (in_x && ((bus.VGA_ypos == Y_TOP)  || (bus.VGA_ypos == Y_BOT)));
    assign sep_c    = (off[SEG_W_LOG2-1:0] == '0) && (off != 11'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_inside <= 1'b0;
            s1_border <= 1'b0;
            s1_sep    <= 1'b0;
            s1_en     <= 1'b0;
            s1_seg    <= 5'd0;
        end else begin
            s1_inside <= in_x && in_y;
            s1_border <= border_c;
            s1_sep    <= sep_c;
            s1_en     <= bus.enable;
            s1_seg    <= seg;
        end
    end

    // Stage 2: colour selection against the frame-stable levels.
    logic [11:0] pix_c, pix_out;

    always_comb begin
        pix_c = 12'h000;
        if (s1_en && s1_inside) begin
            if (s1_border) begin
                pix_c = BORDER_COLOR;
            end else if (s1_sep) begin
                pix_c = 12'h000;
            end else if ((state == DRAIN) && (s1_seg >= tgt_lvl) && (s1_seg < disp_lvl)) begin
                pix_c = 12'hFFF;
            end else if ((s1_seg < disp_lvl) && !blank) begin
                pix_c = FILL_COLOR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out <= 12'h000;
        end else begin
            pix_out <= pix_c;
        end
    end

    assign bus.VGA_data = pix_out;

endmodule

`default_nettype wire

// File: doc/game_status_bar.md
# game_status_bar

Parametrised segmented status-bar renderer for the game HUD: draws an N-segment bar (HP or remaining time) at a configurable screen position and ORs into the VGA pixel stream beside the mode-caption logic. Unlike a static bar, the displayed level slews one segment per frame toward the target value, and a white "ghost" marks segments being drained. Optionally the fill blinks while the level is low. Output is pipelined and frame-synchronous to avoid tearing.

## Interface
- X0, 320: left edge x of bar (border column)
- Y0, 52: top edge y of bar (border row)
- SEG_H, 16: bar height in pixels; bottom border at Y0+SEG_H
- SEG_W_LOG2, 4: log2 of segment width in pixels (segment width = 2^SEG_W_LOG2)
- SEG_MAX, 9: number of segments, 1..31
- VAL_W, 5: width of value input
- LOW_THRESH, 2: level at or below which blink applies (level ≥ 1)
- BLINK_FRAMES, 16: frames per blink phase, ≥ 1
- FILL_COLOR, 12'hF00: segment fill colour
- BORDER_COLOR, 12'hF00: outline colour

- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  bar visible and animating
- frame_tick  in  1  one-cycle pulse per frame, issued during vertical blanking
- value  in  VAL_W  target level, unsigned
- VGA_xpos  in  11  current pixel x
- VGA_ypos  in  11  current pixel y
- VGA_data  out  12  RGB444 pixel, black outside the bar
- anim_busy  out  1  high while displayed level ≠ target level

## Operation
- Registers: tgt_lvl, disp_lvl (5 bits each), state, blink_cnt, blink_phase.
- On frame_tick with enable=1: tgt_lvl ← min(value, SEG_MAX). value is sampled only at frame_tick.
- State machine (evaluated on frame_tick, against the newly latched tgt_lvl):
  - IDLE: disp_lvl = tgt_lvl. If the new target > disp_lvl, go to FILL. If it is < disp_lvl, go to DRAIN.
  - FILL: disp_lvl += 1 per frame_tick. Go to IDLE when disp_lvl reaches the target. Go to DRAIN if the target drops below disp_lvl.
  - DRAIN: disp_lvl −= 1 per frame_tick. Go to IDLE when disp_lvl reaches the target. Go to FILL if the target rises above disp_lvl.
  - The step is exactly 1 per tick; never overshoot.
- anim_busy = (state ≠ IDLE), registered.
- enable=0: tgt_lvl, disp_lvl ← 0; state ← IDLE; blink counters cleared; VGA_data black. enable has priority over a coincident frame_tick.
- After enable rises, the bar fills from 0 at 1 segment/frame.
- Pixel classification, with offset o = x−X0 and segment s = o >> SEG_W_LOG2:
  - Border: x==X0 or x==X0+SEG_MAX·2^SEG_W_LOG2, with Y0≤y≤Y0+SEG_H; or y==Y0 or y==Y0+SEG_H, with x inside the span.
  - Separator: o[SEG_W_LOG2−1:0]==0 and o≠0 → black.
  - Ghost: state==DRAIN and tgt_lvl ≤ s < disp_lvl → 12'hFFF.
  - Fill: s < disp_lvl → FILL_COLOR, or black if blanked by blink.
  - Otherwise black.
  - Priority: border > separator > ghost > fill > black.

## Timing
- Reset values: VGA_data=0, anim_busy=0, tgt_lvl=0, disp_lvl=0, state=IDLE, blink_cnt=0, blink_phase=0 (visible).
- Pixel path is a 2-stage pipeline:
  - Stage 1 registers the region compare and s.
  - Stage 2 registers VGA_data.
  - VGA_data for (x,y) appears 2 clk after VGA_xpos/VGA_ypos present (x,y).
- tgt_lvl, disp_lvl and state update in the cycle after the frame_tick edge. anim_busy follows one cycle later.
- Levels change only at frame_tick, so every visible line of a frame uses the same levels.
- value > SEG_MAX saturates to SEG_MAX. value = 0 empties the bar. Width arithmetic is 11-bit unsigned, with no wrap for in-range parameters.
- rst mid-animation: immediate return to reset values. The pipeline output forces black within 0 cycles, because the reset is asynchronous.

## Configuration
- STATUS_BAR_BLINK_EN defined: on each frame_tick, while 1 ≤ disp_lvl ≤ LOW_THRESH:
  - blink_cnt increments.
  - At BLINK_FRAMES−1, blink_cnt wraps to 0 and blink_phase toggles.
  - Fill pixels are black while blink_phase=1.
  - Outside the low range, blink_cnt=0 and blink_phase=0.
  - Border and ghost never blink.
- Undefined: no blink logic. Fill is always drawn.

## Test plan
- Reset, enable=1, value=5, 8 frame_ticks → disp_lvl 1,2,3,4,5 on ticks 1–5. anim_busy=1 through tick 4, drops after tick 5. Pixel (X0+40,Y0+8) = 12'hF00, since s=2 < 5.
- From level 5, value=2 → DRAIN. On the tick that sets disp_lvl=4, pixel (X0+56,Y0+8), s=3, is 12'hFFF. After 3 ticks it is black, state is IDLE, anim_busy=0.
- value=31 with SEG_MAX=9 → settles at disp_lvl=9. Pixel (X0+144,Y0+8) is the border (BORDER_COLOR); pixel (X0+160,Y0+8) is black.
- Mid-FILL (disp_lvl=3, target 7), value=1 at the next tick → state DRAIN, disp_lvl=2 then 1, then IDLE.
- Separator and border checks: (X0+16,Y0+8) black; (X0,Y0+8), (X0+8,Y0), (X0+8,Y0+16) = BORDER_COLOR. Latency is exactly 2 clk.
- With STATUS_BAR_BLINK_EN, level 2, BLINK_FRAMES=16: fill is visible for ticks 1–15 and black for ticks 16–31. Assert rst mid-frame → VGA_data=0 immediately, disp_lvl=0.
